// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED pattern sequencer:
//   - led_mode_e : 2-bit pattern mode encoding (BLINK, SCAN, COUNT, FILL)
//   - led_dir_e  : scan direction state (UP = towards MSB, DOWN = towards LSB)
//   - LED_WIDTH_DEFAULT : default number of board LEDs
// -----------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_COUNT = 2'd2,
        MODE_FILL  = 2'd3
    } led_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } led_dir_e;

    localparam int LED_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/led_sequencer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the upstream tick strobe down to one pattern step every
// TICKS_PER_STEP ticks. Counting pauses (count held) while enable is low.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-low reset (clears the count)
//   tick    in   one-cycle strobe from the compare stage
//   enable  in   high = count ticks, low = hold
//   step    out  combinational; high in the cycle whose tick completes a step
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICKS_PER_STEP = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic enable,
    output logic step
);

    // A 1-bit counter is kept even when TICKS_PER_STEP==1 so the code stays
    // uniform; it simply never leaves zero in that case.
    localparam int CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

    logic [CW-1:0] r_count;
    logic          w_count_tick;

    assign w_count_tick = tick & enable;
    assign step         = w_count_tick & (r_count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_count_tick) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
// Animated LED pattern engine driven by the compare-stage match strobe.
// Each prescaled step either loads a newly selected mode (no advance) or
// advances the active pattern by one position.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   tick        in   one-cycle strobe from the compare stage
//   enable      in   high = run, low = freeze prescaler and pattern
//   mode        in   0 BLINK, 1 SCAN, 2 COUNT, 3 FILL
//   led         out  registered LED drive (WIDTH bits)
//   cycle_done  out  one-cycle pulse when a pattern period completes
// Optional build macro LED_ACTIVE_LOW_EN: when defined, led is the bitwise
// inverse of the internal pattern (reset value all-ones); nothing else changes.
// -----------------------------------------------------------------------------
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH          = LED_WIDTH_DEFAULT,
    parameter int TICKS_PER_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             enable,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             cycle_done
);

    logic             w_step;
    led_mode_e        w_mode_in;

    logic [WIDTH-1:0] r_pattern;
    led_mode_e        r_mode;
    led_dir_e         r_dir;
    logic             r_cycle_done;

    logic [WIDTH-1:0] w_pattern_next;
    led_mode_e        w_mode_next;
    led_dir_e         w_dir_next;
    logic             w_done_next;

    logic             w_all_ones;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;

    tick_prescaler #(
        .TICKS_PER_STEP (TICKS_PER_STEP)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .enable (enable),
        .step   (w_step)
    );

    assign w_mode_in  = led_mode_e'(mode);
    assign w_all_ones = &r_pattern;
    assign w_shl      = {r_pattern[WIDTH-2:0], 1'b0};
    assign w_shr      = {1'b0, r_pattern[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern    <= '0;
            r_mode       <= MODE_BLINK;
            r_dir        <= DIR_UP;
            r_cycle_done <= 1'b0;
        end else begin
            r_pattern    <= w_pattern_next;
            r_mode       <= w_mode_next;
            r_dir        <= w_dir_next;
            r_cycle_done <= w_done_next;
        end
    end

    always_comb begin
        w_pattern_next = r_pattern;
        w_mode_next    = r_mode;
        w_dir_next     = r_dir;
        w_done_next    = 1'b0;

        if (w_step) begin
            if (w_mode_in != r_mode) begin
                // Mode load: jump to the new mode's initial pattern, no advance.
                w_mode_next    = w_mode_in;
                w_dir_next     = DIR_UP;
                w_pattern_next = (w_mode_in == MODE_SCAN) ? WIDTH'(1) : '0;
            end else begin
                case (r_mode)
                    MODE_BLINK: begin
                        w_pattern_next = ~r_pattern;
                        w_done_next    = w_all_ones;
                    end
                    MODE_SCAN: begin
                        if (r_dir == DIR_UP) begin
                            w_pattern_next = w_shl;
                            if (w_shl[WIDTH-1]) w_dir_next = DIR_DOWN;
                        end else begin
                            w_pattern_next = w_shr;
                            if (w_shr[0]) begin
                                w_dir_next  = DIR_UP;
                                w_done_next = 1'b1;
                            end
                        end
                    end
                    MODE_COUNT: begin
                        w_pattern_next = r_pattern + 1'b1;
                        w_done_next    = w_all_ones;
                    end
                    default: begin // MODE_FILL
                        w_pattern_next = w_all_ones ? '0 : {r_pattern[WIDTH-2:0], 1'b1};
                        w_done_next    = w_all_ones;
                    end
                endcase
            end
        end
    end

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~r_pattern;
`else
    assign led = r_pattern;
`endif
    assign cycle_done = r_cycle_done;

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
// Self-checking bench for led_sequencer (WIDTH=8, TICKS_PER_STEP=3).
// The reference model tracks the active mode and the number of steps taken
// since the last mode load; the expected LED value is computed directly from
// that position within the pattern period. Honours LED_ACTIVE_LOW_EN.
// -----------------------------------------------------------------------------
module tb_led_sequencer;

    localparam int W   = 8;
    localparam int TPS = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         tick;
    logic         enable;
    logic [1:0]   mode;
    logic [W-1:0] led;
    logic         cycle_done;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_mode;
    int m_pos;
    int m_cnt;
    bit m_done;

    led_sequencer #(
        .WIDTH          (W),
        .TICKS_PER_STEP (TPS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .enable     (enable),
        .mode       (mode),
        .led        (led),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    function automatic int period_of(input int md);
        case (md)
            0:       return 2;
            1:       return 2 * (W - 1);
            2:       return 1 << W;
            default: return W + 1;
        endcase
    endfunction

    function automatic logic [W-1:0] pattern_at(input int md, input int p);
        int q;
        q = p % period_of(md);
        case (md)
            0:       return (q == 1) ? {W{1'b1}} : '0;
            1:       return (q < W) ? W'(1 << q) : W'(1 << (2 * (W - 1) - q));
            2:       return W'(q);
            default: return W'((1 << q) - 1);
        endcase
    endfunction

    function automatic logic [W-1:0] exp_led();
`ifdef LED_ACTIVE_LOW_EN
        return ~pattern_at(m_mode, m_pos);
`else
        return pattern_at(m_mode, m_pos);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pos  = 0;
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    // Predicts the state produced by the next rising edge for these inputs.
    task automatic model_update(input bit t, input bit e, input int md);
        m_done = 1'b0;
        if (t && e) begin
            if (m_cnt == TPS - 1) begin
                m_cnt = 0;
                if (md != m_mode) begin
                    m_mode = md;
                    m_pos  = 0;
                end else begin
                    m_pos++;
                    m_done = ((m_pos % period_of(m_mode)) == 0);
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    // One clock: check current outputs, then drive inputs for the next edge.
    task automatic cyc(input bit t, input bit e, input int md);
        @(negedge clk);
        check("led", 32'(led), 32'(exp_led()));
        check("cycle_done", 32'(cycle_done), 32'(m_done));
        tick   = t;
        enable = e;
        mode   = 2'(md);
        model_update(t, e, md);
    endtask

    task automatic async_reset();
        @(negedge clk);
        check("led_pre_rst", 32'(led), 32'(exp_led()));
        #1 reset = 1'b0;
        tick = 1'b0;
        #1;
        model_reset();
        check("led_async_rst", 32'(led), 32'(exp_led()));
        check("done_async_rst", 32'(cycle_done), 32'd0);
        cyc(1, 1, 1);
        m_cnt = 0; m_pos = 0; m_mode = 0; m_done = 1'b0; // held in reset
        cyc(0, 1, 0);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        tick   = 1'b0;
        enable = 1'b0;
        mode   = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_led", 32'(led), 32'(exp_led()));
        check("reset_done", 32'(cycle_done), 32'd0);
        reset = 1'b1;

        // BLINK: 4 steps, each tick on consecutive cycles
        for (int i = 0; i < 4 * TPS; i++) cyc(1, 1, 0);
        cyc(0, 1, 0);

        // SCAN: load + one full period, ticks interleaved with idle cycles
        for (int i = 0; i < 15 * TPS; i++) cyc(1, 1, 1);
        for (int i = 0; i < 10; i++) cyc(i % 2, 1, 1);

        // COUNT: load, then full wrap
        for (int i = 0; i < 257 * TPS + 3; i++) cyc(1, 1, 2);

        // freeze at prescale count 1
        for (int i = 0; i < 10 && m_cnt != 1; i++) cyc(1, 1, 2);
        check("cnt_at_1", 32'(m_cnt), 32'd1);
        for (int i = 0; i < 50; i++) cyc(1, 0, 2);
        cyc(1, 1, 2);
        cyc(1, 1, 2);
        cyc(0, 1, 2);
        check("step_after_freeze", 32'(m_cnt), 32'd0);

        // FILL: load, full period, then switch to SCAN mid-fill
        for (int i = 0; i < 10 * TPS; i++) cyc(1, 1, 3);
        for (int i = 0; i < 4 * TPS; i++) cyc(1, 1, 3);
        for (int i = 0; i < 2; i++) cyc(0, 1, 1);
        for (int i = 0; i < TPS; i++) cyc(1, 1, 1);
        cyc(0, 1, 1);

        // run SCAN to 0x10 then reset asynchronously
        for (int i = 0; i < 200 && pattern_at(m_mode, m_pos) != W'(8'h10); i++) cyc(1, 1, 1);
        check("scan_reach_10", 32'(pattern_at(m_mode, m_pos)), 32'h10);
        cyc(0, 1, 1);
        async_reset();

        // randomized run
        begin
            int rm;
            rm = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 63) == 0) rm = int'($urandom_range(0, 3));
                cyc(bit'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), rm);
                if (i == 2500) async_reset();
            end
        end
        cyc(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
